// File: rtl/key_matrix_scan_pkg.sv
// rtl/key_matrix_scan_pkg.sv - shared constants, types and helpers for the key matrix scanner
// Purpose : matrix geometry, game key codes, the frame type and frame-decoding helpers.
// Ports   : none (package).
package key_matrix_scan_pkg;

  localparam int N_COLS  = 4;
  localparam int N_ROWS  = 4;
  localparam int COL_W   = $clog2(N_COLS);
  localparam int ROW_W   = $clog2(N_ROWS);
  localparam int FRAME_W = 16;
  localparam int CODE_W  = COL_W + ROW_W;

  localparam logic [CODE_W-1:0] KEY_LEFT  = 4'd0;
  localparam logic [CODE_W-1:0] KEY_RIGHT = 4'd1;
  localparam logic [CODE_W-1:0] KEY_PAUSE = 4'd2;
  localparam logic [CODE_W-1:0] KEY_START = 4'd3;

  // One bit per key, bit index = col*N_ROWS + row, 1 = key down.
  typedef logic [FRAME_W-1:0] frame_t;

  function automatic logic is_single_key(input frame_t f);
    int n;
    n = 0;
    for (int i = 0; i < FRAME_W; i++) begin
      n += int'(f[i]);
    end
    return (n == 1);
  endfunction

  // Only meaningful when exactly one bit is set.
  function automatic logic [CODE_W-1:0] key_index(input frame_t f);
    logic [CODE_W-1:0] idx;
    idx = '0;
    for (int i = 0; i < FRAME_W; i++) begin
      if (f[i]) idx = CODE_W'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/key_matrix_scan_tick.sv
// rtl/key_matrix_scan_tick.sv - column dwell divider and column index for the key matrix scanner
// Purpose : counts TICK_DIV cycles per column, flags the last dwell cycle and steps the column.
// Ports   : clk_i         system clock
//           rst_i         synchronous active-high reset
//           sample_tick_o high during the last cycle of each column dwell
//           col_idx_o     column currently driven (0..N_COLS-1)
module scan_tick_gen
  import key_matrix_scan_pkg::*;
#(
  parameter int TICK_DIV = 50000
) (
  input  logic             clk_i,
  input  logic             rst_i,
  output logic             sample_tick_o,
  output logic [COL_W-1:0] col_idx_o
);

  localparam int CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(TICK_DIV - 1);

  logic [CNT_W-1:0] dwell_q, dwell_d;
  logic [COL_W-1:0] col_q, col_d;
  logic             wrap;

  always_comb begin
    wrap    = (dwell_q == LAST);
    dwell_d = wrap ? '0 : dwell_q + CNT_W'(1);
    // Column index wraps naturally since N_COLS is a power of two.
    col_d   = wrap ? col_q + COL_W'(1) : col_q;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      dwell_q <= '0;
      col_q   <= '0;
    end else begin
      dwell_q <= dwell_d;
      col_q   <= col_d;
    end
  end

  assign sample_tick_o = wrap;
  assign col_idx_o     = col_q;

endmodule

// File: rtl/key_matrix_scan.sv
// rtl/key_matrix_scan.sv - 4x4 active-low key matrix scanner with frame debounce and press events
// Purpose : drives one column at a time, samples rows at dwell end, debounces whole 16-key frames
//           and emits a one-cycle event when the matrix goes from no key to exactly one key.
// Ports   : clk_50m   system clock
//           rst       synchronous active-high reset
//           row_in    matrix rows, active-low, asynchronous
//           col_out   column drive, active-low one-hot
//           key_code  code (col*4+row) of the last accepted single press
//           key_valid one-cycle pulse on an accepted single press
//           key_held  debounced state has at least one key down
module key_matrix_scan
  import key_matrix_scan_pkg::*;
#(
  parameter int CLK_HZ          = 50000000,
  parameter int SCAN_HZ         = 1000,
  parameter int DEBOUNCE_FRAMES = 4
) (
  input  logic              clk_50m,
  input  logic              rst,
  input  logic [N_ROWS-1:0] row_in,
  output logic [N_COLS-1:0] col_out,
  output logic [CODE_W-1:0] key_code,
  output logic              key_valid,
  output logic              key_held
);

  localparam int TICK_DIV = CLK_HZ / SCAN_HZ;
  localparam logic [3:0] STABLE_MAX = 4'(DEBOUNCE_FRAMES - 1);

  logic [N_ROWS-1:0] row_sync1_q, row_sync2_q;
  logic              sample_tick;
  logic [COL_W-1:0]  col_idx;
  logic              frame_done;

  frame_t            raw_q, raw_d;
  frame_t            prev_q;
  frame_t            deb_q, deb_d;
  logic [3:0]        stable_q, stable_d;
  logic              accept;
  logic              press_evt;

  logic [CODE_W-1:0] key_code_q;
  logic              key_valid_q;
  logic              key_held_q;

  scan_tick_gen #(
    .TICK_DIV (TICK_DIV)
  ) u_tick (
    .clk_i         (clk_50m),
    .rst_i         (rst),
    .sample_tick_o (sample_tick),
    .col_idx_o     (col_idx)
  );

  assign col_out    = ~(N_COLS'(1) << col_idx);
  assign frame_done = sample_tick && (col_idx == COL_W'(N_COLS - 1));

  always_comb begin
    raw_d = raw_q;
    if (sample_tick) begin
      for (int r = 0; r < N_ROWS; r++) begin
        raw_d[{col_idx, ROW_W'(r)}] = ~row_sync2_q[r];
      end
    end

    // raw_d already contains the last column's nibble on the frame-complete cycle.
    if (raw_d == prev_q) begin
      stable_d = (stable_q == STABLE_MAX) ? stable_q : stable_q + 4'd1;
    end else begin
      stable_d = 4'd0;
    end

    accept    = (stable_d == STABLE_MAX) && (raw_d != deb_q);
    deb_d     = accept ? raw_d : deb_q;
    // Only a press out of the idle state counts; roll-over and chords stay silent.
    press_evt = (deb_q == '0) && is_single_key(deb_d);
  end

  always_ff @(posedge clk_50m) begin
    if (rst) begin
      row_sync1_q <= '1;
      row_sync2_q <= '1;
      raw_q       <= '0;
      prev_q      <= '0;
      deb_q       <= '0;
      stable_q    <= '0;
      key_code_q  <= '0;
      key_valid_q <= 1'b0;
      key_held_q  <= 1'b0;
    end else begin
      row_sync1_q <= row_in;
      row_sync2_q <= row_sync1_q;
      raw_q       <= raw_d;
      key_valid_q <= 1'b0;
      if (frame_done) begin
        prev_q      <= raw_d;
        stable_q    <= stable_d;
        deb_q       <= deb_d;
        key_held_q  <= (deb_d != '0);
        key_valid_q <= press_evt;
        if (press_evt) key_code_q <= key_index(deb_d);
      end
    end
  end

  assign key_code  = key_code_q;
  assign key_valid = key_valid_q;
  assign key_held  = key_held_q;

endmodule

// File: tb/tb_key_matrix_scan.sv
// tb/tb_key_matrix_scan.sv - self-checking bench for key_matrix_scan
module tb_key_matrix_scan;

  localparam int TICK = 10;
  localparam int FRAME = 4 * TICK;

  logic       clk_50m = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] row_in;
  logic [3:0] col_out;
  logic [3:0] key_code;
  logic       key_valid;
  logic       key_held;

  logic [15:0] keys = 16'h0;
  int          cyc = 0;
  int          checks = 0;
  int          passes = 0;

  typedef struct {
    int code;
    int at_cyc;
  } exp_evt_t;
  exp_evt_t evq[$];

  typedef struct {
    logic [15:0] keys;
    int          frames;
    int          ev_code;
    logic        exp_held;
    logic [3:0]  exp_code;
  } phase_t;

  key_matrix_scan #(
    .CLK_HZ          (1000),
    .SCAN_HZ         (100),
    .DEBOUNCE_FRAMES (3)
  ) dut (
    .clk_50m   (clk_50m),
    .rst       (rst),
    .row_in    (row_in),
    .col_out   (col_out),
    .key_code  (key_code),
    .key_valid (key_valid),
    .key_held  (key_held)
  );

  always #5 clk_50m = ~clk_50m;

  // Physical matrix: a pressed key shorts its row to its column when that column is driven low.
  always_comb begin
    row_in = 4'hF;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        if (!col_out[c] && keys[c*4+r]) row_in[r] = 1'b0;
      end
    end
  end

  always @(posedge clk_50m) begin
    if (rst) cyc <= 0;
    else     cyc <= cyc + 1;
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act == exp) passes++;
    else $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
  endtask

  // Event scoreboard and column-walk check.
  always @(negedge clk_50m) begin
    if (!rst && (cyc % TICK) == 5) begin
      chk("col_out", int'(col_out), int'(~(4'b0001 << ((cyc / TICK) % 4)) & 4'hF));
    end
    if (key_valid) begin
      if (evq.size() == 0) begin
        chk("unexpected_key_valid", int'(key_code), -1);
      end else begin
        exp_evt_t e;
        e = evq.pop_front();
        chk("event_code", int'(key_code), e.code);
        if (e.at_cyc >= 0) chk("event_cycle", cyc, e.at_cyc);
      end
    end
  end

  task automatic do_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk_50m);
    chk("rst_col_out", int'(col_out), 4'b1110);
    chk("rst_key_valid", int'(key_valid), 0);
    chk("rst_key_held", int'(key_held), 0);
    chk("rst_key_code", int'(key_code), 0);
    rst = 1'b0;
  endtask

  // Waits n frames, then checks just after the monitor has consumed any event at that edge.
  task automatic run_frames(input string tag, input int n, input logic held, input logic [3:0] code);
    repeat (n * FRAME) @(negedge clk_50m);
    #1;
    chk({tag, "_held"}, int'(key_held), int'(held));
    chk({tag, "_code"}, int'(key_code), int'(code));
    chk({tag, "_pending_events"}, evq.size(), 0);
  endtask

  phase_t ph[17];

  initial begin
    ph[0]  = '{16'h0200, 1, -1, 1'b0, 4'd0};
    ph[1]  = '{16'h0000, 1, -1, 1'b0, 4'd0};
    ph[2]  = '{16'h0200, 1, -1, 1'b0, 4'd0};
    ph[3]  = '{16'h0000, 3, -1, 1'b0, 4'd0};
    ph[4]  = '{16'h1000, 2, -1, 1'b0, 4'd0};
    ph[5]  = '{16'h0000, 3, -1, 1'b0, 4'd0};
    ph[6]  = '{16'h0008, 4,  3, 1'b1, 4'd3};
    ph[7]  = '{16'h0000, 2, -1, 1'b1, 4'd3};
    ph[8]  = '{16'h0000, 2, -1, 1'b0, 4'd3};
    ph[9]  = '{16'h0008, 3,  3, 1'b1, 4'd3};
    ph[10] = '{16'h0000, 3, -1, 1'b0, 4'd3};
    ph[11] = '{16'h0021, 5, -1, 1'b1, 4'd3};
    ph[12] = '{16'h0001, 4, -1, 1'b1, 4'd3};
    ph[13] = '{16'h0000, 3, -1, 1'b0, 4'd3};
    ph[14] = '{16'h0200, 3,  9, 1'b1, 4'd9};
    ph[15] = '{16'h0400, 4, -1, 1'b1, 4'd9};
    ph[16] = '{16'h0000, 3, -1, 1'b0, 4'd9};

    // Idle matrix: columns walk, nothing is reported.
    keys = 16'h0;
    do_reset();
    run_frames("idle", 3, 1'b0, 4'd0);

    // Key 9 (col 2, row 1) down from reset release: event exactly at cycle 120.
    keys = 16'h0200;
    evq.push_back('{9, 120});
    do_reset();
    repeat (119) @(negedge clk_50m);
    chk("k9_no_early_held", int'(key_held), 0);
    run_frames("k9", 1, 1'b1, 4'd9);
    keys = 16'h0;
    repeat (5) @(negedge clk_50m);

    // Phase table: bounce, sub-threshold press, release timing, chords, roll-over.
    keys = 16'h0;
    do_reset();
    for (int i = 0; i < 17; i++) begin
      keys = ph[i].keys;
      if (ph[i].ev_code >= 0) evq.push_back('{ph[i].ev_code, -1});
      run_frames($sformatf("phase%0d", i), ph[i].frames, ph[i].exp_held, ph[i].exp_code);
    end

    // Reset mid-frame with key 7 held aborts the frame; a fresh press follows 3 frames later.
    keys = 16'h0080;
    evq.push_back('{7, -1});
    run_frames("k7_pre", 4, 1'b1, 4'd7);
    repeat (15) @(negedge clk_50m);
    rst = 1'b1;
    @(negedge clk_50m);
    chk("midrst_col_out", int'(col_out), 4'b1110);
    chk("midrst_key_held", int'(key_held), 0);
    chk("midrst_key_code", int'(key_code), 0);
    chk("midrst_key_valid", int'(key_valid), 0);
    evq.push_back('{7, 120});
    rst = 1'b0;
    run_frames("k7_post", 4, 1'b1, 4'd7);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
